// File: rtl/ethpipe_pkg.sv
// Shared definitions for the GMII RX pipeline: FSM encodings, header geometry,
// preamble/SFD bytes and the CRC-32 constants used by the FCS checker.
package ethpipe_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_HDR    = 3'd2,
    RX_COMMIT = 3'd3,
    RX_DROP   = 3'd4
  } rx_state_t;

  localparam int          RX_HDR_WORDS    = 7;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;

  // One byte of the reflected (LSB-first) Ethernet CRC-32, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CRC32_POLY_REFL : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_fcs_chk.sv
// Running CRC-32 over every byte after the SFD, FCS included; a good frame
// leaves the fixed residue in the register.
module rx_fcs_chk
  import ethpipe_pkg::*;
(
  input  logic       gmii_rx_clk,
  input  logic       sys_rst,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic       fcs_ok
);

  logic [31:0] crc;
  logic [31:0] crc_rev;

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst || init) begin
      crc <= '1;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

  // The residue constant is stated MSB-first, the register is kept reflected.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 32; i++) begin
      crc_rev[i] = crc[31-i];
    end
  end

  assign fcs_ok = (crc_rev == CRC32_RESIDUE);

endmodule

// File: rtl/receiver.sv
// GMII receive engine: SFD detect, timestamp, FCS check, big-endian packing into the
// RX slot ring behind a 7-word header. Define RX_BAD_FRAME_KEEP_EN to keep FCS-bad frames.
module receiver
  import ethpipe_pkg::*;
#(
  parameter logic [15:0] MIN_LEN = 16'd64,
  parameter logic [15:0] MAX_LEN = 16'd1522
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [15:0] slot_rx_eth_data,
  output logic [1:0]  slot_rx_eth_byte_en,
  output logic [13:0] slot_rx_eth_addr,
  output logic        slot_rx_eth_wr_en,
  output logic [13:0] mem_wr_ptr,
  input  logic [13:0] mem_rd_ptr,
  output logic [15:0] rx_drop_cnt
);

  rx_state_t   state, state_next;
  logic [15:0] cnt;
  logic [13:0] wa;
  logic [7:0]  tmp;
  logic [63:0] ts;
  logic [31:0] fcs_sr;
  logic [2:0]  hdr_idx;
  logic        fcs_ok;
  logic        sfd, wa_hit;
  logic        start, take, pack_wr, flush_wr, drop_evt, mark_bad, hdr_wr, commit;
  logic [13:0] free_words;
  logic [15:0] len;
  logic [15:0] hdr_word;

  assign sfd        = gmii_rx_dv && (gmii_rxd == SFD_BYTE);
  assign free_words = mem_rd_ptr - mem_wr_ptr - 14'd1;
  assign wa_hit     = ((wa + 14'd1) == mem_rd_ptr);
  assign len        = cnt - 16'd4;

  rx_fcs_chk u_fcs (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst     (sys_rst),
    .init        (start),
    .en          (take),
    .data        (gmii_rxd),
    .fcs_ok      (fcs_ok)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    pack_wr    = 1'b0;
    flush_wr   = 1'b0;
    drop_evt   = 1'b0;
    mark_bad   = 1'b0;
    hdr_wr     = 1'b0;
    commit     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (sfd) begin
          if (free_words >= 14'd8) begin
            start      = 1'b1;
            state_next = RX_DATA;
          end else begin
            drop_evt   = 1'b1;
            state_next = RX_DROP;
          end
        end
      end
      RX_DATA: begin
        if (gmii_rx_dv) begin
          // A word landing on mem_rd_ptr-1 would leave the ring looking empty.
          if (gmii_rx_er || (({1'b0, cnt} + 17'd1) > {1'b0, MAX_LEN}) || (cnt[0] && wa_hit)) begin
            drop_evt   = 1'b1;
            state_next = RX_DROP;
          end else begin
            take    = 1'b1;
            pack_wr = cnt[0];
          end
        end else begin
          flush_wr = cnt[0] && !wa_hit;
          if (cnt[0] && wa_hit) begin
            drop_evt   = 1'b1;
            state_next = RX_IDLE;
          end else if (cnt < MIN_LEN) begin
            drop_evt   = 1'b1;
            state_next = RX_IDLE;
          end else if (!fcs_ok) begin
`ifdef RX_BAD_FRAME_KEEP_EN
            mark_bad   = 1'b1;
            state_next = RX_HDR;
`else
            drop_evt   = 1'b1;
            state_next = RX_IDLE;
`endif
          end else begin
            state_next = RX_HDR;
          end
        end
      end
      RX_HDR: begin
        hdr_wr = 1'b1;
        if (hdr_idx == 3'(RX_HDR_WORDS - 1)) state_next = RX_COMMIT;
      end
      RX_COMMIT: begin
        commit     = 1'b1;
        state_next = RX_IDLE;
      end
      RX_DROP: begin
        if (!gmii_rx_dv) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    hdr_word = '0;
    case (hdr_idx)
      3'd0:    hdr_word = len;
      3'd1:    hdr_word = ts[63:48];
      3'd2:    hdr_word = ts[47:32];
      3'd3:    hdr_word = ts[31:16];
      3'd4:    hdr_word = ts[15:0];
      3'd5:    hdr_word = fcs_sr[31:16];
      3'd6:    hdr_word = fcs_sr[15:0];
      default: hdr_word = '0;
    endcase
  end

  // Slot port: wr_en pulses one cycle per word; data/addr/byte_en hold otherwise.
  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      state               <= RX_IDLE;
      cnt                 <= '0;
      wa                  <= '0;
      tmp                 <= '0;
      ts                  <= '0;
      fcs_sr              <= '0;
      hdr_idx             <= '0;
      slot_rx_eth_data    <= '0;
      slot_rx_eth_byte_en <= '0;
      slot_rx_eth_addr    <= '0;
      slot_rx_eth_wr_en   <= 1'b0;
      mem_wr_ptr          <= '0;
      rx_drop_cnt         <= '0;
    end else begin
      state             <= state_next;
      slot_rx_eth_wr_en <= 1'b0;
      if (start) begin
        ts      <= global_counter;
        cnt     <= '0;
        wa      <= mem_wr_ptr + 14'(RX_HDR_WORDS);
        hdr_idx <= '0;
      end
      if (take) begin
        cnt    <= cnt + 16'd1;
        fcs_sr <= {fcs_sr[23:0], gmii_rxd};
        if (!cnt[0]) tmp <= gmii_rxd;
      end
      if (pack_wr) begin
        slot_rx_eth_data    <= {tmp, gmii_rxd};
        slot_rx_eth_byte_en <= 2'b11;
        slot_rx_eth_addr    <= wa;
        slot_rx_eth_wr_en   <= 1'b1;
        wa                  <= wa + 14'd1;
      end
      if (flush_wr) begin
        slot_rx_eth_data    <= {tmp, 8'h00};
        slot_rx_eth_byte_en <= 2'b10;
        slot_rx_eth_addr    <= wa;
        slot_rx_eth_wr_en   <= 1'b1;
      end
      if (mark_bad) ts[63] <= 1'b1;
      if (hdr_wr) begin
        slot_rx_eth_data    <= hdr_word;
        slot_rx_eth_byte_en <= 2'b11;
        slot_rx_eth_addr    <= mem_wr_ptr + 14'(hdr_idx);
        slot_rx_eth_wr_en   <= 1'b1;
        hdr_idx             <= hdr_idx + 3'd1;
      end
      // FCS words sit past the committed end and get overwritten by the next frame.
      if (commit) mem_wr_ptr <= mem_wr_ptr + 14'(RX_HDR_WORDS) + 14'((({1'b0, len} + 17'd1) >> 1));
      if (drop_evt && (rx_drop_cnt != 16'hFFFF)) rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end

endmodule
